// File: rtl/logic_unit.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshake.
// S1 holds the raw result; S2 holds the result and its zero/neg/parity flags.
module logic_unit #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             zero,
  output logic             neg,
  output logic             parity
);

  localparam logic [2:0] OP_NOT  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_ANDN = 3'b111;

  logic             v1_q, v1_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] r1_q, r1_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             p_q, p_d;
  logic             adv1, adv2, fire_in;
  logic [WIDTH-1:0] res;

  assign adv2    = !ov_q || out_ready;
  assign adv1    = !v1_q || adv2;
  assign fire_in = in_valid && adv1;

  always_comb begin
    res = '0;
    unique case (op)
      OP_NOT:  res = ~a;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      OP_XNOR: res = ~(a ^ b);
      OP_ANDN: res = a & ~b;
    endcase
  end

  always_comb begin
    v1_d = v1_q;
    r1_d = r1_q;
    if (adv1) begin
      v1_d = fire_in;
      r1_d = res;
    end
  end

  // Flags are derived from r1 so they always match the c they travel with.
  always_comb begin
    ov_d = ov_q;
    c_d  = c_q;
    z_d  = z_q;
    n_d  = n_q;
    p_d  = p_q;
    if (adv2) begin
      ov_d = v1_q;
      c_d  = r1_q;
      z_d  = (r1_q == '0);
      n_d  = r1_q[WIDTH-1];
      p_d  = ^r1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      r1_q <= '0;
      ov_q <= 1'b0;
      c_q  <= '0;
      z_q  <= 1'b0;
      n_q  <= 1'b0;
      p_q  <= 1'b0;
    end else begin
      v1_q <= v1_d;
      r1_q <= r1_d;
      ov_q <= ov_d;
      c_q  <= c_d;
      z_q  <= z_d;
      n_q  <= n_d;
      p_q  <= p_d;
    end
  end

  assign in_ready  = adv1;
  assign out_valid = ov_q;
  assign c         = c_q;
  assign zero      = z_q;
  assign neg       = n_q;
  assign parity    = p_q;

endmodule
